// File: rtl/sm2201_isa_pkg.sv
// sm2201_isa_pkg: shared FSM state type, address-window defaults and byte-select codes
//   for the SM2201 ISA I/O cycle controller. No ports.
package sm2201_isa_pkg;
  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, HOLD} cyc_state_e;
  localparam logic [9:0] DEF_BASE_ADDR = 10'h100;
  localparam int DEF_WINDOW = 64;
  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;
endpackage

// File: rtl/isa_io_cycle_controller_if.sv
// isa_io_cycle_controller_if: request/acknowledge link between the ISA cycle controller and the CAMAC bus sequencer
//   cb_reg    5   register index (addr[5:1])
//   cb_wdata  16  write word {high byte, low byte}
//   cb_wr_req 1   write request level, held until ack
//   cb_rd_req 1   read request level, held until ack
//   cb_rdata  16  read word, valid while cb_ack is high
//   cb_ack    1   sequencer acknowledge
//   master = ISA cycle controller, slave = CAMAC sequencer
interface isa_io_cycle_controller_if;
  logic [4:0] cb_reg;
  logic [15:0] cb_wdata;
  logic cb_wr_req;
  logic cb_rd_req;
  logic [15:0] cb_rdata;
  logic cb_ack;
  modport master(output cb_reg, cb_wdata, cb_wr_req, cb_rd_req, input cb_rdata, cb_ack);
  modport slave(input cb_reg, cb_wdata, cb_wr_req, cb_rd_req, output cb_rdata, cb_ack);
endinterface

// File: rtl/isa_strobe_sync.sv
// isa_strobe_sync: 2-flop synchronizer for an active-low ISA strobe with falling/rising edge pulses
//   isa_clk   in   clock
//   isa_reset in   asynchronous active-low reset
//   strobe_n  in   raw strobe pin, asynchronous to isa_clk
//   fall      out  one-cycle pulse when the synchronized strobe goes low
//   rise      out  one-cycle pulse when the synchronized strobe goes high
module isa_strobe_sync (
  input  logic isa_clk,
  input  logic isa_reset,
  input  logic strobe_n,
  output logic fall,
  output logic rise
);
  // s[1:0] is the synchronizer chain, s[2] the previous synchronized value
  logic [2:0] s;
  always_ff @(posedge isa_clk or negedge isa_reset)
    if (!isa_reset) s <= '1;
    else s <= {s[1:0], strobe_n};
  assign fall = s[2] & ~s[1];
  assign rise = ~s[2] & s[1];
endmodule

// File: rtl/isa_io_cycle_controller.sv
// isa_io_cycle_controller: decodes ISA I/O cycles in a 64-byte window and pairs byte accesses into 16-bit CAMAC transfers
//   isa_clk, isa_reset (async active-low)
//   isa_addr[9:0], isa_aen, isa_ior, isa_iow, isa_data_in[7:0]   ISA inputs
//   isa_data_out[7:0], isa_data_oe, isa_chrdy                    ISA outputs
//   camac (master modport)                                       CAMAC request/ack link
//   cycle_err                                                    sticky timeout flag
//   ISA_CYCLE_TIMEOUT_EN: when defined, a request unanswered for TIMEOUT cycles is abandoned
module isa_io_cycle_controller
  import sm2201_isa_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int WINDOW = DEF_WINDOW
`ifdef ISA_CYCLE_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic isa_clk,
  input  logic isa_reset,
  input  logic [9:0] isa_addr,
  input  logic isa_aen,
  input  logic isa_ior,
  input  logic isa_iow,
  input  logic [7:0] isa_data_in,
  output logic [7:0] isa_data_out,
  output logic isa_data_oe,
  output logic isa_chrdy,
  isa_io_cycle_controller_if.master camac,
  output logic cycle_err
);
  cyc_state_e state;
  logic is_rd, hit, rd_go, wr_go, done, tmo;
  logic ior_fall, ior_rise, iow_fall, iow_rise;
  logic [7:0] wr_lo;
  logic [15:0] rd_buf;
  isa_strobe_sync u_ior (.isa_clk, .isa_reset, .strobe_n(isa_ior), .fall(ior_fall), .rise(ior_rise));
  isa_strobe_sync u_iow (.isa_clk, .isa_reset, .strobe_n(isa_iow), .fall(iow_fall), .rise(iow_rise));
  assign hit = !isa_aen && {1'b0, isa_addr} >= {1'b0, BASE_ADDR} && {1'b0, isa_addr} < 11'(BASE_ADDR + WINDOW);
  // a read edge in the same cycle as a write edge wins; the write is dropped
  assign rd_go = ior_fall & hit;
  assign wr_go = iow_fall & ~ior_fall & hit;
  assign done = camac.cb_ack | tmo;
`ifdef ISA_CYCLE_TIMEOUT_EN
  logic [7:0] cnt;
  logic busy;
  assign busy = state == RD_REQ || state == WR_REQ;
  assign tmo = busy && cnt == 8'(TIMEOUT);
  always_ff @(posedge isa_clk or negedge isa_reset)
    if (!isa_reset) begin
      cnt <= '0;
      cycle_err <= 1'b0;
    end else begin
      cnt <= busy ? cnt + 8'(!tmo) : 8'd0;
      cycle_err <= cycle_err | (tmo & ~camac.cb_ack);
    end
`else
  assign tmo = 1'b0;
  assign cycle_err = 1'b0;
`endif
  always_ff @(posedge isa_clk or negedge isa_reset)
    if (!isa_reset) begin
      state <= IDLE;
      is_rd <= 1'b0;
      wr_lo <= '0;
      rd_buf <= '0;
      isa_data_out <= '0;
      isa_data_oe <= 1'b0;
      isa_chrdy <= 1'b1;
      camac.cb_reg <= '0;
      camac.cb_wdata <= '0;
      camac.cb_wr_req <= 1'b0;
      camac.cb_rd_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rd_go || wr_go) begin
          is_rd <= rd_go;
          camac.cb_reg <= isa_addr[5:1];
          if (rd_go && isa_addr[0] == BYTE_LO) begin
            state <= RD_REQ;
            camac.cb_rd_req <= 1'b1;
            isa_chrdy <= 1'b0;
          end else if (wr_go && isa_addr[0] == BYTE_HI) begin
            state <= WR_REQ;
            camac.cb_wdata <= {isa_data_in, wr_lo};
            camac.cb_wr_req <= 1'b1;
            isa_chrdy <= 1'b0;
          end else begin
            state <= HOLD;
            isa_data_oe <= rd_go;
            if (rd_go) isa_data_out <= rd_buf[15:8];
            else wr_lo <= isa_data_in;
          end
        end
        // an abandoned read returns all-ones
        RD_REQ: if (done) begin
          state <= HOLD;
          camac.cb_rd_req <= 1'b0;
          isa_chrdy <= 1'b1;
          rd_buf <= camac.cb_ack ? camac.cb_rdata : 16'hFFFF;
          isa_data_out <= camac.cb_ack ? camac.cb_rdata[7:0] : 8'hFF;
          isa_data_oe <= 1'b1;
        end
        WR_REQ: if (done) begin
          state <= HOLD;
          camac.cb_wr_req <= 1'b0;
          isa_chrdy <= 1'b1;
        end
        HOLD: if (is_rd ? ior_rise : iow_rise) begin
          state <= IDLE;
          isa_data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_isa_io_cycle_controller.sv
// tb_isa_io_cycle_controller: randomized self-checking bench against a transaction-level model of the byte-pairing rules
module tb_isa_io_cycle_controller;
  logic isa_clk = 1'b0;
  logic isa_reset = 1'b0;
  logic [9:0] isa_addr = '0;
  logic isa_aen = 1'b0;
  logic isa_ior = 1'b1;
  logic isa_iow = 1'b1;
  logic [7:0] isa_data_in = '0;
  logic [7:0] isa_data_out;
  logic isa_data_oe;
  logic isa_chrdy;
  logic cycle_err;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_wr_lo = '0;
  logic [15:0] m_rd_buf = '0;
  isa_io_cycle_controller_if cbi ();
  isa_io_cycle_controller dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
    .camac(cbi.master), .cycle_err(cycle_err)
  );
  always #5 isa_clk = ~isa_clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // kind: 0 write, 1 read, 2 read and write strobes together
  task automatic access(input int kind, input logic [9:0] a, input logic aen, input logic [7:0] d,
                        input int dly, input logic [15:0] rdat);
    bit rd, hit, exp_rd, exp_wr;
    int n_rd, n_wr, low, cnt;
    bit pr, pw;
    logic [4:0] reg_seen;
    logic [15:0] wd_seen;
    rd = kind != 0;
    hit = !aen && a >= 10'h100 && a < 10'h140;
    exp_rd = hit && rd && !a[0];
    exp_wr = hit && !rd && a[0];
    n_rd = 0; n_wr = 0; low = 0; cnt = -1; pr = 0; pw = 0; reg_seen = '0; wd_seen = '0;
    isa_addr = a; isa_aen = aen; isa_data_in = d; cbi.cb_rdata = rdat;
    @(negedge isa_clk);
    isa_ior = (kind == 0);
    isa_iow = (kind == 1);
    for (int c = 0; c < dly + 16; c++) begin
      @(posedge isa_clk); #1;
      if (cbi.cb_ack) begin
        chk("ack_release", {cbi.cb_rd_req, cbi.cb_wr_req, isa_chrdy}, 3'b001);
        cbi.cb_ack = 1'b0;
      end
      if (cbi.cb_rd_req && !pr) n_rd++;
      if (cbi.cb_wr_req && !pw) begin n_wr++; wd_seen = cbi.cb_wdata; end
      if ((cbi.cb_rd_req || cbi.cb_wr_req) && !pr && !pw) begin reg_seen = cbi.cb_reg; cnt = dly; end
      pr = cbi.cb_rd_req; pw = cbi.cb_wr_req;
      if (!isa_chrdy) low++;
      if (cnt == 0) begin cbi.cb_ack = 1'b1; cnt = -1; end
      else if (cnt > 0) cnt--;
    end
    cbi.cb_ack = 1'b0;
    chk("rd_req_count", n_rd, exp_rd ? 1 : 0);
    chk("wr_req_count", n_wr, exp_wr ? 1 : 0);
    chk("chrdy_low_cycles", low, (exp_rd || exp_wr) ? dly + 1 : 0);
    if (exp_rd || exp_wr) chk("cb_reg", reg_seen, a[5:1]);
    if (exp_wr) chk("cb_wdata", wd_seen, {d, m_wr_lo});
    if (exp_rd) m_rd_buf = rdat;
    if (hit && !rd && !a[0]) m_wr_lo = d;
    chk("oe_hold", isa_data_oe, hit && rd);
    if (hit && rd) chk("rd_data", isa_data_out, a[0] ? m_rd_buf[15:8] : m_rd_buf[7:0]);
    isa_ior = 1'b1; isa_iow = 1'b1;
    repeat (5) @(posedge isa_clk);
    #1;
    chk("release_idle", {isa_data_oe, isa_chrdy}, 2'b01);
  endtask
  initial begin
    cbi.cb_ack = 1'b0;
    cbi.cb_rdata = '0;
    repeat (3) @(negedge isa_clk);
    chk("reset_vals", {isa_data_out, isa_data_oe, isa_chrdy, cbi.cb_reg, cbi.cb_wdata, cbi.cb_wr_req, cbi.cb_rd_req, cycle_err},
        {8'h00, 1'b0, 1'b1, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0});
    isa_reset = 1'b1;
    repeat (3) @(negedge isa_clk);
    access(0, 10'h110, 1'b0, 8'h34, 0, 16'h0);
    access(0, 10'h111, 1'b0, 8'h12, 3, 16'h0);
    access(1, 10'h120, 1'b0, 8'h00, 5, 16'h4208);
    access(1, 10'h121, 1'b0, 8'h00, 0, 16'h0);
    access(0, 10'h0F0, 1'b0, 8'h55, 0, 16'h0);
    access(1, 10'h140, 1'b0, 8'h00, 0, 16'h0);
    access(0, 10'h110, 1'b1, 8'h77, 0, 16'h0);
    access(0, 10'h13F, 1'b0, 8'hA5, 1, 16'h0);
    // simultaneous strobes: read of the high byte only; a following high write shows wr_lo kept
    access(2, 10'h101, 1'b0, 8'hEE, 0, 16'h0);
    access(0, 10'h103, 1'b0, 8'h9C, 2, 16'h0);
    // reset while a read request is outstanding
    isa_addr = 10'h100; isa_aen = 1'b0;
    @(negedge isa_clk);
    isa_ior = 1'b0;
    for (int c = 0; c < 10 && !cbi.cb_rd_req; c++) begin
      @(posedge isa_clk); #1;
    end
    chk("rst_pre_req", cbi.cb_rd_req, 1'b1);
    @(negedge isa_clk); #2;
    isa_reset = 1'b0;
    #1;
    chk("rst_async", {isa_data_out, isa_data_oe, isa_chrdy, cbi.cb_reg, cbi.cb_wdata, cbi.cb_wr_req, cbi.cb_rd_req, cycle_err},
        {8'h00, 1'b0, 1'b1, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0});
    isa_ior = 1'b1;
    repeat (2) @(negedge isa_clk);
    isa_reset = 1'b1;
    m_rd_buf = '0; m_wr_lo = '0;
    repeat (3) @(negedge isa_clk);
    access(1, 10'h101, 1'b0, 8'h00, 0, 16'h0);
    access(1, 10'h100, 1'b0, 8'h00, 2, 16'hBEEF);
    access(0, 10'h105, 1'b0, 8'h11, 0, 16'h0);
    for (int i = 0; i < 40; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) != 0) ? 10'(10'h100 + $urandom_range(0, 63)) : 10'($urandom);
      access(int'($urandom_range(0, 1)), a, $urandom_range(0, 7) == 0, 8'($urandom),
             int'($urandom_range(0, 6)), 16'($urandom));
    end
`ifdef ISA_CYCLE_TIMEOUT_EN
    begin
      int n;
      n = 0;
      isa_addr = 10'h100; isa_aen = 1'b0;
      @(negedge isa_clk);
      isa_ior = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(posedge isa_clk); #1;
        if (cbi.cb_rd_req) n++;
      end
      chk("tmo_req_cycles", n >= 254 && n <= 257, 1'b1);
      chk("tmo_state", {cbi.cb_rd_req, cycle_err, isa_chrdy, isa_data_oe, isa_data_out}, {4'b0111, 8'hFF});
      isa_ior = 1'b1;
      repeat (5) @(negedge isa_clk);
      m_rd_buf = 16'hFFFF;
      access(1, 10'h101, 1'b0, 8'h00, 0, 16'h0);
      chk("cycle_err_final", cycle_err, 1'b1);
    end
`else
    chk("cycle_err_final", cycle_err, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
